// File: rtl/run_seq_pkg.sv
// Shared types and default parameters for the run sequencer.
package run_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

  localparam int          DEF_PW        = 2;
  localparam int          DEF_CW        = 16;
  localparam int          DEF_START_CYC = 2;
  localparam int unsigned DEF_TIMEOUT   = 32'h0000_FFFF;

endpackage

// File: rtl/run_sequencer_cyc_counter.sv
// Loadable/clearable up-counter with a terminal-match flag.
module cyc_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] match_val,
  output logic [W-1:0] count,
  output logic         at_match
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign at_match = (count == match_val);

endmodule

// File: rtl/run_sequencer.sv
// Sequences the core through one program run per request: start pulse,
// cycle counting with watchdog, and a held response until the host takes it.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int          PW        = DEF_PW,
  parameter int          CW        = DEF_CW,
  parameter int          START_CYC = DEF_START_CYC,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [PW-1:0] req_prog,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [CW-1:0] rsp_cycles,
  output logic          rsp_timeout,
  output logic [PW-1:0] rsp_prog,
  output logic          core_start,
  output logic [PW-1:0] core_prog_sel,
  input  logic          core_done,
  output logic          busy
);

  localparam logic [CW-1:0] START_LAST = CW'(START_CYC);
  localparam logic [CW-1:0] RUN_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TO_VALUE   = CW'(TIMEOUT);

  seq_state_t    state;
  seq_state_t    next_state;
  logic          accept;
  logic          start_done;
  logic          run_to;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] start_cnt_unused;

  assign accept = (state == IDLE) && req_valid;

  // Hold counter runs 1..START_CYC; only its terminal match matters.
  cyc_counter #(.W(CW)) u_start_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .load      (accept),
    .load_val  (CW'(1)),
    .inc       ((state == START) && !start_done),
    .match_val (START_LAST),
    .count     (start_cnt_unused),
    .at_match  (start_done)
  );

  // run_cnt holds completed RUN cycles, so a match on TIMEOUT-1 means this is cycle TIMEOUT.
  cyc_counter #(.W(CW)) u_run_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     ((state == START) && start_done),
    .load      (1'b0),
    .load_val  ('0),
    .inc       ((state == RUN) && !core_done && !run_to),
    .match_val (RUN_LAST),
    .count     (run_cnt),
    .at_match  (run_to)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (req_valid)            next_state = START;
      START: if (start_done)           next_state = RUN;
      RUN:   if (core_done || run_to)  next_state = RESP;
      RESP:  if (rsp_ready)            next_state = IDLE;
      default:                         next_state = IDLE;
    endcase
  end

  // Outputs decode only the state register, so none follows an input combinationally.
  always_comb begin
    req_ready  = (state == IDLE);
    core_start = (state == START);
    rsp_valid  = (state == RESP);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_prog_sel <= '0;
      rsp_prog      <= '0;
      rsp_cycles    <= '0;
      rsp_timeout   <= 1'b0;
    end else begin
      if (accept) begin
        core_prog_sel <= req_prog;
        rsp_prog      <= req_prog;
      end
      if (state == RUN) begin
        if (core_done) begin
          rsp_cycles  <= run_cnt + 1'b1;
          rsp_timeout <= 1'b0;
        end else if (run_to) begin
          rsp_cycles  <= TO_VALUE;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
Host-side controller that sequences the single-cycle processor core through complete program runs. It accepts a run request, drives the core's start pulse, and counts execution cycles until the core raises done. A watchdog timeout bounds runaway programs, and each finished run returns its cycle count and status on a response handshake. It sits between the testbench/host harness and top_level's start/done pins.

Parameters:
PW, 2, width of program-select field passed to the core
CW, 16, width of cycle counter and rsp_cycles
START_CYC, 2, number of cycles core_start is held high per run (>=1)
TIMEOUT, 16'hFFFF, RUN cycles before the watchdog fires (1 .. 2^CW-1)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; low forces all state to reset values immediately
req_valid  in  1  host run request valid
req_ready  out  1  sequencer can accept a request
req_prog  in  PW  program select for this run
rsp_valid  out  1  run result valid
rsp_ready  in  1  host accepts result
rsp_cycles  out  CW  RUN cycles counted for the finished run
rsp_timeout  out  1  1 = run ended by watchdog, 0 = ended by core_done
rsp_prog  out  PW  program select of the finished run
core_start  out  1  drives core start (core held at PC 0 while high)
core_prog_sel  out  PW  program select to core, stable from accept until next accept
core_done  in  1  core halt indication (combinational from core)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_cycles=0, rsp_timeout=0, rsp_prog=0, core_start=0, core_prog_sel=0, busy=0.
- States: IDLE, START, RUN, RESP.
- IDLE: req_ready=1. On req_valid & req_ready at edge k: latch req_prog into core_prog_sel and rsp_prog, load start counter, go to START.
- START: core_start=1 for exactly START_CYC cycles (k+1 .. k+START_CYC). core_done is ignored. Then go to RUN, with run counter cleared to 0.
- RUN: core_start=0. Each cycle, sample core_done; n = run_cnt+1.
  - core_done=1: rsp_cycles<=n, rsp_timeout<=0, go to RESP.
  - else if n==TIMEOUT: rsp_cycles<=TIMEOUT, rsp_timeout<=1, go to RESP.
  - else run_cnt<=n.
  - core_done and timeout in the same cycle: done wins, rsp_timeout=0.
- Counting: the first RUN cycle counts as 1. A core that is done on its first RUN cycle reports rsp_cycles=1.
- RESP: rsp_valid=1, with rsp_* held stable until rsp_valid & rsp_ready, then go to IDLE. There is no combinational path from rsp_ready to req_ready; the next request is accepted at the earliest on the cycle after the response handshake.
- req_ready is 0 in START, RUN and RESP; requests in those states wait (host holds req_valid).
- Latency: core_done seen in RUN cycle c → rsp_valid high in cycle c+1.
- Counter width: run_cnt is CW bits and cannot overflow, because TIMEOUT <= 2^CW-1.
- Reset mid-operation: returns to IDLE with the reset values above. Any pending response is discarded and core_start drops immediately (asynchronously).
- All outputs are registered; no output depends combinationally on an input.

Decomposition:
- Package run_seq_pkg: enum typedef seq_state_t {IDLE, START, RUN, RESP}; default constants for PW, CW, START_CYC, TIMEOUT.
- One sub-module, cyc_counter: loadable/clearable up-counter with terminal-match output. It is used twice: for the START hold count and for the RUN count.

Test Plan:
- Normal run, START_CYC=2: request prog=1, core_done rises on the 5th RUN cycle → core_start high exactly 2 cycles; rsp_valid the next cycle with cycles=5, timeout=0, prog=1.
- Watchdog, TIMEOUT=8: core_done never asserts → rsp_valid after 8 RUN cycles with cycles=8, timeout=1.
- Done/timeout collision, TIMEOUT=4: core_done first high on RUN cycle 4 → cycles=4, timeout=0.
- core_done held high throughout START, then still high in RUN cycle 1 → done ignored in START; rsp cycles=1.
- Back-pressure: rsp_ready held low 10 cycles with req_valid high → rsp_* stable, req_ready=0; rsp_ready=1 → IDLE, second request accepted the following cycle.
- Reset pulsed low mid-RUN → outputs immediately at reset values, state IDLE; a fresh request runs normally with cycles counted from 1.
